// File: rtl/cpu_mul_seq_if.sv
// Request/response and multiply-cell signals of the multiply sequencer.
// slave: the sequencer side. master: issue logic, result consumer and cell.
interface cpu_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;

    modport slave (
        input  req_valid, req_op, req_a, req_b, kill, resp_ready,
        input  cell_p1, cell_p2, cell_p3,
        output req_ready, resp_valid, resp_result,
        output cell_src1, cell_src2, cell_en
    );

    modport master (
        output req_valid, req_op, req_a, req_b, kill, resp_ready,
        output cell_p1, cell_p2, cell_p3,
        input  req_ready, resp_valid, resp_result,
        input  cell_src1, cell_src2, cell_en
    );
endinterface

// File: rtl/cpu_mul_seq.sv
// Multiply sequencer: drives the 3-product multiply cell for one pass (MUL)
// or two passes (MULX*, adding the hi*hi product) and assembles the result.
module cpu_mul_seq (
    input  logic            clk,
    input  logic            reset,
    cpu_mul_seq_if.slave    bus
);
    typedef enum logic [2:0] {StIdle, StIssue1, StCap1, StCap2, StDone} state_e;

    localparam logic [1:0] OpMul    = 2'd0;
    localparam logic [1:0] OpMulxsu = 2'd2;
    localparam logic [1:0] OpMulxss = 2'd3;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic        en_q, en_d;

    logic [63:0] mid;
    logic [63:0] corr;

    // Next-state, operand latching, accumulation and cell drive.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        // Cross products summed at full 33-bit width before alignment.
        mid     = ({32'h0, bus.cell_p2} + {32'h0, bus.cell_p3}) << 16;
        corr    = 64'h0;
        if ((op_q == OpMulxsu || op_q == OpMulxss) && a_q[31]) begin
            corr = corr + {b_q, 32'h0};
        end
        if (op_q == OpMulxss && b_q[31]) begin
            corr = corr + {a_q, 32'h0};
        end

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    src1_d  = bus.req_a;
                    src2_d  = bus.req_b;
                    state_d = StIssue1;
                end
            end
            StIssue1: begin
                // Stage the hi halves so they reach the cell during CAP1.
                if (op_q != OpMul) begin
                    src1_d = {16'h0, a_q[31:16]};
                    src2_d = {16'h0, b_q[31:16]};
                end
                state_d = StCap1;
            end
            StCap1: begin
                acc_d   = {32'h0, bus.cell_p1} + mid;
                state_d = (op_q == OpMul) ? StDone : StCap2;
            end
            StCap2: begin
                acc_d   = acc_q + {bus.cell_p1, 32'h0} - corr;
                state_d = StDone;
            end
            StDone: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush outranks everything, including a pending handshake.
        if (bus.kill && state_q != StIdle) begin
            state_d = StIdle;
        end

        en_d = (state_d == StIssue1) || (state_d == StCap1 && op_d != OpMul);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 2'd0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            acc_q   <= 64'h0;
            src1_q  <= 32'h0;
            src2_q  <= 32'h0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            en_q    <= en_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        bus.req_ready   = (state_q == StIdle);
        bus.resp_valid  = (state_q == StDone);
        bus.resp_result = (op_q == OpMul) ? acc_q[31:0] : acc_q[63:32];
        bus.cell_src1   = src1_q;
        bus.cell_src2   = src2_q;
        bus.cell_en     = en_q;
    end
endmodule

// File: tb/tb_cpu_mul_seq.sv
// Bench for cpu_mul_seq: directed requests against a 1-clk enabled cell model,
// with a scoreboard monitor checking response latency and value.
module tb_cpu_mul_seq;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    bit   seen;

    cpu_mul_seq_if bus ();

    cpu_mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiply cell model: products registered when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cell_p1 <= 32'h0;
            bus.cell_p2 <= 32'h0;
            bus.cell_p3 <= 32'h0;
        end else if (bus.cell_en) begin
            bus.cell_p1 <= {16'h0, bus.cell_src1[15:0]} * {16'h0, bus.cell_src2[15:0]};
            bus.cell_p2 <= {16'h0, bus.cell_src1[15:0]} * {16'h0, bus.cell_src2[31:16]};
            bus.cell_p3 <= {16'h0, bus.cell_src1[31:16]} * {16'h0, bus.cell_src2[15:0]};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on first valid cycle, value on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            seen = 1'b0;
        end else if (bus.resp_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {32'h0, bus.resp_result}, 64'hDEAD);
                end else begin
                    chk("resp_latency", 64'(cyc), {32'h0, sb[0].cyc});
                end
            end
            if (bus.resp_ready) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("resp_result", {32'h0, bus.resp_result}, {32'h0, e.res});
                end
                seen = 1'b0;
            end
        end
    end

    // Present a request until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit expect_resp);
        bit ok;
        exp_t e;
        ok            = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 64'h0, 64'h1);
        end else if (expect_resp) begin
            e.res = exp;
            e.cyc = 32'(cyc) + ((op == 2'd0) ? 32'd3 : 32'd4);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        // Garbage after accept must not reach the latched operands.
        bus.req_valid = 1'b0;
        bus.req_op    = ~op;
        bus.req_a     = 32'hA5A5_5A5A;
        bus.req_b     = 32'h5A5A_A5A5;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.req_ready && !bus.resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'h0, 64'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        cyc            = 0;
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_a      = 32'h0;
        bus.req_b      = 32'h0;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b1;
        #3;
        chk("rst_req_ready", {63'h0, bus.req_ready}, 64'h1);
        chk("rst_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        chk("rst_resp_result", {32'h0, bus.resp_result}, 64'h0);
        chk("rst_cell_en", {63'h0, bus.cell_en}, 64'h0);
        chk("rst_cell_src1", {32'h0, bus.cell_src1}, 64'h0);
        chk("rst_cell_src2", {32'h0, bus.cell_src2}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // MUL 3*5 with cell_en pulse only in the issue cycle.
        send(2'd0, 32'd3, 32'd5, 32'h0000_000F, 1'b1);
        chk("mul_en_t1", {63'h0, bus.cell_en}, 64'h1);
        chk("mul_src1_t1", {32'h0, bus.cell_src1}, 64'h3);
        chk("mul_src2_t1", {32'h0, bus.cell_src2}, 64'h5);
        chk("mul_rdy_t1", {63'h0, bus.req_ready}, 64'h0);
        @(posedge clk);
        #1;
        chk("mul_en_t2", {63'h0, bus.cell_en}, 64'h0);
        @(posedge clk);
        #1;
        chk("mul_en_t3", {63'h0, bus.cell_en}, 64'h0);
        wait_idle();

        send(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        wait_idle();
        send(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_idle();
        send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        send(2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1);
        wait_idle();
        send(2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        wait_idle();
        send(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        wait_idle();
        send(2'd2, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        send(2'd3, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        // Back-pressure: result held stable while resp_ready is low.
        bus.resp_ready = 1'b0;
        send(2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("hold_timeout", 64'h0, 64'h1);
        for (int k = 0; k < 3; k++) begin
            chk("hold_valid", {63'h0, bus.resp_valid}, 64'h1);
            chk("hold_result", {32'h0, bus.resp_result}, 64'h4000_0000);
            chk("hold_req_ready", {63'h0, bus.req_ready}, 64'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", {63'h0, bus.resp_valid}, 64'h0);
        chk("release_req_ready", {63'h0, bus.req_ready}, 64'h1);

        // Kill in CAP1 of a MULXSS: no response, cell idles next clock.
        send(2'd3, 32'h1234_5678, 32'h8765_4321, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("kill_cap1_en", {63'h0, bus.cell_en}, 64'h1);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        chk("kill_en", {63'h0, bus.cell_en}, 64'h0);
        chk("kill_valid", {63'h0, bus.resp_valid}, 64'h0);
        chk("kill_req_ready", {63'h0, bus.req_ready}, 64'h1);
        repeat (5) @(posedge clk);
        #1;
        send(2'd0, 32'd9, 32'd11, 32'd99, 1'b1);
        wait_idle();

        // Async reset during CAP2 of a MULXUU.
        send(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_req_ready", {63'h0, bus.req_ready}, 64'h1);
        chk("arst_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        chk("arst_resp_result", {32'h0, bus.resp_result}, 64'h0);
        chk("arst_cell_en", {63'h0, bus.cell_en}, 64'h0);
        chk("arst_cell_src1", {32'h0, bus.cell_src1}, 64'h0);
        chk("arst_cell_src2", {32'h0, bus.cell_src2}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(2'd0, 32'd7, 32'd6, 32'd42, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
